// File: rtl/mac_tcdm_req_buffer_pkg.sv
// Shared types and constants for the TCDM request buffer.
// The request record is a single packed word (69 bits) so the FIFO can store it directly.
package mac_package;

    typedef struct packed {
        logic [31:0] add;
        logic        wen;
        logic [3:0]  be;
        logic [31:0] data;
    } mac_tcdm_req_t;

    localparam int unsigned MAC_TCDM_BUF_DEPTH_DEFAULT = 4;
    localparam int unsigned MAC_OUTST_W                = 3;

    // A response with nothing outstanding is a protocol error and must not underflow the counter.
    function automatic logic [MAC_OUTST_W-1:0] outst_next(
        input logic [MAC_OUTST_W-1:0] cur,
        input logic                   issue,
        input logic                   resp
    );
        logic retire;
        retire = resp && (cur != '0);
        case ({issue, retire})
            2'b10:   return cur + 1'b1;
            2'b01:   return cur - 1'b1;
            default: return cur;
        endcase
    endfunction

endpackage

// File: rtl/mac_tcdm_req_buffer_fifo.sv
// Circular request FIFO for the TCDM buffer; DEPTH must be a power of two so the
// pointers wrap naturally. The head entry is read straight from storage registers.
module mac_tcdm_fifo
    import mac_package::*;
#(
    parameter int unsigned DEPTH = MAC_TCDM_BUF_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  mac_tcdm_req_t            wdata,
    input  logic                     pop,
    output mac_tcdm_req_t            rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    mac_tcdm_req_t mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage carries no reset; entries are only observed while count says they are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/mac_tcdm_req_buffer.sv
// Request buffer between an accelerator and the TCDM interconnect, with an outstanding
// limiter and registered response path. Optional stall counter: MAC_TCDM_BUF_PERF_EN.
module mac_tcdm_req_buffer
    import mac_package::*;
#(
    parameter int unsigned DEPTH     = MAC_TCDM_BUF_DEPTH_DEFAULT,
    parameter int unsigned MAX_OUTST = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   s_req,
    output logic                   s_gnt,
    input  logic [31:0]            s_add,
    input  logic                   s_wen,
    input  logic [3:0]             s_be,
    input  logic [31:0]            s_data,
    output logic [31:0]            s_r_data,
    output logic                   s_r_valid,
    output logic                   m_req,
    input  logic                   m_gnt,
    output logic [31:0]            m_add,
    output logic                   m_wen,
    output logic [3:0]             m_be,
    output logic [31:0]            m_data,
    input  logic [31:0]            m_r_data,
    input  logic                   m_r_valid,
    output logic [$clog2(DEPTH):0] occupancy_o,
    output logic                   busy_o
`ifdef MAC_TCDM_BUF_PERF_EN
    ,
    output logic [31:0]            stall_cnt_o
`endif
);

    localparam logic [MAC_OUTST_W-1:0] MAX_CNT = MAC_OUTST_W'(MAX_OUTST);

    mac_tcdm_req_t            s_pkt;
    mac_tcdm_req_t            m_pkt;
    logic                     full;
    logic                     empty;
    logic                     push;
    logic                     pop;
    logic [MAC_OUTST_W-1:0]   outst;

    assign s_pkt = '{add: s_add, wen: s_wen, be: s_be, data: s_data};

    // A flush refuses any same-cycle push, so nothing new survives the clear.
    assign s_gnt = !full && !clear_i;
    assign push  = s_req && s_gnt;
    assign m_req = !empty && (outst < MAX_CNT);
    assign pop   = m_req && m_gnt;

    assign m_add  = m_pkt.add;
    assign m_wen  = m_pkt.wen;
    assign m_be   = m_pkt.be;
    assign m_data = m_pkt.data;

    assign busy_o = !empty || (outst != '0);

    mac_tcdm_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .clear (clear_i),
        .push  (push),
        .wdata (s_pkt),
        .pop   (pop),
        .rdata (m_pkt),
        .full  (full),
        .empty (empty),
        .count (occupancy_o)
    );

    // The clear flush deliberately leaves in-flight requests and their responses alone.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outst <= '0;
        end else begin
            outst <= outst_next(outst, pop, m_r_valid);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s_r_valid <= 1'b0;
            s_r_data  <= '0;
        end else begin
            s_r_valid <= m_r_valid;
            if (m_r_valid) begin
                s_r_data <= m_r_data;
            end
        end
    end

`ifdef MAC_TCDM_BUF_PERF_EN
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            stall_cnt_o <= '0;
        end else if (m_req && !m_gnt && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mac_tcdm_req_buffer.sv
// Self-checking bench for mac_tcdm_req_buffer: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_mac_tcdm_req_buffer;

    localparam int DEPTH     = 4;
    localparam int MAX_OUTST = 2;

    typedef struct packed {
        logic [31:0] add;
        logic        wen;
        logic [3:0]  be;
        logic [31:0] data;
    } ref_req_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        s_req = 1'b0;
    logic        s_gnt;
    logic [31:0] s_add = '0;
    logic        s_wen = 1'b0;
    logic [3:0]  s_be = '0;
    logic [31:0] s_data = '0;
    logic [31:0] s_r_data;
    logic        s_r_valid;
    logic        m_req;
    logic        m_gnt = 1'b0;
    logic [31:0] m_add;
    logic        m_wen;
    logic [3:0]  m_be;
    logic [31:0] m_data;
    logic [31:0] m_r_data = '0;
    logic        m_r_valid = 1'b0;
    logic [2:0]  occupancy_o;
    logic        busy_o;
`ifdef MAC_TCDM_BUF_PERF_EN
    logic [31:0] stall_cnt_o;
`endif

    int compared = 0;
    int mismatched = 0;
    bit check_en = 1'b0;

    ref_req_t    mq[$];
    int          ref_outst = 0;
    logic        ref_rv = 1'b0;
    logic [31:0] ref_rd = '0;
`ifdef MAC_TCDM_BUF_PERF_EN
    logic [31:0] ref_stall = '0;
`endif

    mac_tcdm_req_buffer #(
        .DEPTH     (DEPTH),
        .MAX_OUTST (MAX_OUTST)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (clear_i),
        .s_req       (s_req),
        .s_gnt       (s_gnt),
        .s_add       (s_add),
        .s_wen       (s_wen),
        .s_be        (s_be),
        .s_data      (s_data),
        .s_r_data    (s_r_data),
        .s_r_valid   (s_r_valid),
        .m_req       (m_req),
        .m_gnt       (m_gnt),
        .m_add       (m_add),
        .m_wen       (m_wen),
        .m_be        (m_be),
        .m_data      (m_data),
        .m_r_data    (m_r_data),
        .m_r_valid   (m_r_valid),
        .occupancy_o (occupancy_o),
        .busy_o      (busy_o)
`ifdef MAC_TCDM_BUF_PERF_EN
        ,
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected outputs follow directly from the queue contents and the outstanding count.
    task automatic checkOutput();
        bit exp_gnt;
        bit exp_mreq;
        exp_gnt  = (mq.size() < DEPTH) && !clear_i;
        exp_mreq = (mq.size() > 0) && (ref_outst < MAX_OUTST);
        checkValue("s_gnt", 32'(s_gnt), 32'(exp_gnt));
        checkValue("m_req", 32'(m_req), 32'(exp_mreq));
        checkValue("occupancy", 32'(occupancy_o), 32'(mq.size()));
        checkValue("busy", 32'(busy_o), 32'((mq.size() > 0) || (ref_outst > 0)));
        checkValue("s_r_valid", 32'(s_r_valid), 32'(ref_rv));
        checkValue("s_r_data", s_r_data, ref_rd);
        if (exp_mreq) begin
            checkValue("m_add", m_add, mq[0].add);
            checkValue("m_wen", 32'(m_wen), 32'(mq[0].wen));
            checkValue("m_be", 32'(m_be), 32'(mq[0].be));
            checkValue("m_data", m_data, mq[0].data);
        end
`ifdef MAC_TCDM_BUF_PERF_EN
        checkValue("stall_cnt", stall_cnt_o, ref_stall);
`endif
    endtask

    task automatic modelUpdate();
        bit exp_gnt;
        bit exp_mreq;
        int old_outst;
        exp_gnt   = (mq.size() < DEPTH) && !clear_i;
        exp_mreq  = (mq.size() > 0) && (ref_outst < MAX_OUTST);
        old_outst = ref_outst;
        if (rst_i) begin
            mq.delete();
            ref_outst = 0;
            ref_rv    = 1'b0;
            ref_rd    = '0;
`ifdef MAC_TCDM_BUF_PERF_EN
            ref_stall = '0;
`endif
        end else begin
`ifdef MAC_TCDM_BUF_PERF_EN
            if (clear_i) ref_stall = '0;
            else if (exp_mreq && !m_gnt && ref_stall != 32'hFFFF_FFFF) ref_stall = ref_stall + 1;
`endif
            if (exp_mreq && m_gnt) begin
                void'(mq.pop_front());
                ref_outst++;
            end
            if (m_r_valid && old_outst > 0) ref_outst--;
            if (clear_i) mq.delete();
            else if (s_req && exp_gnt) mq.push_back('{add: s_add, wen: s_wen, be: s_be, data: s_data});
            ref_rv = m_r_valid;
            if (m_r_valid) ref_rd = m_r_data;
        end
    endtask

    // One clock cycle: drive inputs, check at the falling edge, advance the model.
    task automatic applyStimulus(input bit req, input logic [31:0] add, input bit gnt,
                                 input bit rvalid, input logic [31:0] rdata,
                                 input bit clr, input bit rst);
        s_req     = req;
        s_add     = add;
        s_wen     = 1'($urandom);
        s_be      = 4'($urandom);
        s_data    = $urandom;
        m_gnt     = gnt;
        m_r_valid = rvalid;
        m_r_data  = rdata;
        clear_i   = clr;
        rst_i     = rst;
        @(negedge clk_i);
        if (check_en) checkOutput();
        modelUpdate();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1, $urandom, 1'b0, 1'b0);
    endtask

    initial begin
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        check_en = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        checkValue("reset_s_gnt", 32'(s_gnt), 32'd1);
        checkValue("reset_m_req", 32'(m_req), 32'd0);
        checkValue("reset_occupancy", 32'(occupancy_o), 32'd0);
        idle(2);

        // Single read with a response one cycle after the grant.
        applyStimulus(1'b1, 32'h1000, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        checkValue("single_m_req", 32'(m_req), 32'd1);
        checkValue("single_m_add", m_add, 32'h1000);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        checkValue("single_r_valid", 32'(s_r_valid), 32'd1);
        checkValue("single_r_data", s_r_data, 32'hDEADBEEF);
        idle(2);

        // Fill with no grants: only DEPTH requests are accepted.
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 32'h2000 + 32'(4 * i), 1'b0, 1'b0, '0, 1'b0, 1'b0);
        checkValue("fill_occupancy", 32'(occupancy_o), 32'd4);
        checkValue("fill_s_gnt", 32'(s_gnt), 32'd0);
        drain();

        // Throttle: responses withheld stop issue after MAX_OUTST grants.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h3000 + 32'(4 * i), 1'b0, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        checkValue("throttle_m_req_low", 32'(m_req), 32'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'h1111, 1'b0, 1'b0);
        checkValue("throttle_m_req_back", 32'(m_req), 32'd1);
        drain();

        // Wrap: steady simultaneous push/pop at occupancy 3 across many pointer laps.
        for (int s = 0; s < 20; s++) begin
            int len;
            len = int'($urandom_range(2, 8));
            for (int i = 0; i < 3; i++) applyStimulus(1'b1, $urandom, 1'b0, 1'b0, '0, 1'b0, 1'b0);
            for (int i = 0; i < len; i++) applyStimulus(1'b1, $urandom, 1'b1, 1'b1, $urandom, 1'b0, 1'b0);
            checkValue("wrap_occupancy", 32'(occupancy_o), 32'd3);
            drain();
        end

        // Clear with queued entries and one request in flight.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h4000 + 32'(4 * i), 1'b0, 1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h5000, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        checkValue("clear_occupancy", 32'(occupancy_o), 32'd0);
        checkValue("clear_busy", 32'(busy_o), 32'd1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'hCAFE0001, 1'b0, 1'b0);
        checkValue("clear_r_data", s_r_data, 32'hCAFE0001);
        checkValue("clear_idle", 32'(busy_o), 32'd0);

`ifdef MAC_TCDM_BUF_PERF_EN
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h6000, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        checkValue("perf_stall_10", stall_cnt_o, 32'd10);
        drain();
`endif

        // Random traffic with occasional clears and resets.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom,
                          $urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0);
        end

        // Reset in the middle of traffic.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, $urandom, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b1, $urandom, 1'b0, 1'b1, 32'h7777, 1'b0, 1'b1);
        checkValue("midrst_m_req", 32'(m_req), 32'd0);
        checkValue("midrst_s_gnt", 32'(s_gnt), 32'd1);
        checkValue("midrst_busy", 32'(busy_o), 32'd0);
        checkValue("midrst_r_valid", 32'(s_r_valid), 32'd0);
        checkValue("midrst_r_data", s_r_data, 32'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'h8888, 1'b0, 1'b0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mac_tcdm_req_buffer.md
MAC_TCDM_REQ_BUFFER -- requirements
Module: mac_tcdm_req_buffer

Interface
REQ-001 Parameter DEPTH, default 4, request FIFO depth; power of two, 2..16.
REQ-002 Parameter MAX_OUTST, default 2, maximum granted-but-unanswered requests; 1..7.
REQ-003 The block SHALL have exactly one clock, clk_i, and a synchronous, active-high reset, rst_i.
REQ-004 clk_i  in  1  clock; all state on rising edge.
REQ-005 rst_i  in  1  synchronous active-high reset.
REQ-006 clear_i  in  1  synchronous flush of queued, not-yet-issued requests.
REQ-007 s_req/s_gnt  in/out  1/1  accelerator-side request handshake.
REQ-008 s_add/s_wen/s_be/s_data  in  32/1/4/32  accelerator request fields; wen=1 is a read.
REQ-009 s_r_data/s_r_valid  out  32/1  response to accelerator.
REQ-010 m_req/m_gnt  out/in  1/1  interconnect-side request handshake.
REQ-011 m_add/m_wen/m_be/m_data  out  32/1/4/32  head-of-FIFO request fields.
REQ-012 m_r_data/m_r_valid  in  32/1  interconnect response; valid exactly one cycle after the matching m_gnt.
REQ-013 occupancy_o  out  $clog2(DEPTH)+1  current FIFO entries; busy_o  out  1  FIFO non-empty or outstanding count non-zero.

Function
REQ-014 s_gnt SHALL equal !full, combinationally; push occurs when s_req && s_gnt.
REQ-015 m_req SHALL equal !empty && (outst < MAX_OUTST); pop occurs when m_req && m_gnt.
REQ-016 Latency: a request pushed in cycle N SHALL present on m_req no earlier than N+1; no combinational s_* to m_* path.
REQ-017 Requests SHALL leave in push order; m_add/m_wen/m_be/m_data SHALL hold stable while m_req is high and m_gnt is low.
REQ-018 Full: no push, and no same-cycle bypass into a freed slot. Empty: push-only, no bypass to m_*.
REQ-019 Simultaneous push and pop when neither full nor empty: occupancy unchanged; pointers both advance, wrapping modulo DEPTH.
REQ-020 Outstanding counter outst SHALL +1 on pop, -1 on m_r_valid, stay unchanged on both, and never exceed MAX_OUTST.
REQ-021 s_r_valid/s_r_data SHALL be m_r_valid/m_r_data registered by one cycle; s_r_data holds its last value when s_r_valid is low.
REQ-022 clear_i SHALL empty the FIFO next cycle and override a same-cycle push (s_gnt low while clear_i is high), but SHALL NOT alter outst or the response path.
REQ-023 m_r_valid with outst==0 is a protocol error: ignored for the counter, still forwarded.

Reset
REQ-024 rst_i SHALL zero pointers, occupancy_o, outst, s_r_valid, s_r_data, and perf counter; m_req=0, s_gnt=1 the cycle after reset.
REQ-025 Reset mid-transfer SHALL discard queued and outstanding requests; responses arriving after reset are dropped for the counter.
REQ-026 m_* data fields after reset are don't-care while m_req is low.

Configuration
REQ-027 Macro MAC_TCDM_BUF_PERF_EN defined: 32-bit output stall_cnt_o counts cycles with m_req && !m_gnt, saturating at all-ones, zeroed by rst_i or clear_i.
REQ-028 Macro undefined: no stall_cnt_o port and no counter logic; all other behaviour identical.

Structure
REQ-029 mac_package SHALL hold typedef mac_tcdm_req_t (add 32, wen 1, be 4, data 32; packed, 69 bits) and constant MAC_TCDM_BUF_DEPTH_DEFAULT=4.
REQ-030 FIFO storage and pointers SHALL live in one sub-module, mac_tcdm_fifo, parameterised on DEPTH and carrying mac_tcdm_req_t.
REQ-031 Top-level SHALL hold the outstanding counter, response register and perf counter.

Verification
REQ-032 Single read: s_req at add=0x1000 with m_gnt=1 -> m_req in cycle N+1, m_r_valid data 0xDEADBEEF at N+2 -> s_r_valid with 0xDEADBEEF at N+3.
REQ-033 Fill: DEPTH=4, m_gnt=0, 6 back-to-back s_req -> 4 accepted, s_gnt low from the 5th, occupancy_o=4; release m_gnt -> addresses emerge in order.
REQ-034 Throttle: MAX_OUTST=2, m_gnt=1, responses withheld -> m_req drops after 2 grants; one m_r_valid -> m_req reasserts next cycle.
REQ-035 Wrap: 20 random-length streams, simultaneous push/pop at occupancy 3 -> order preserved across pointer wrap, occupancy stable.
REQ-036 clear_i with 3 queued, outst=1 and s_req high -> occupancy_o=0 next cycle, the push is refused, and the pending response is still delivered.
REQ-037 MAC_TCDM_BUF_PERF_EN: m_gnt held low for 10 cycles with m_req high -> stall_cnt_o=10; rst_i mid-stream -> all outputs at reset values next cycle.
